bs_host_ctrl: RTL and testbench

BS_HOST_CTRL -- requirements
Module: bs_host_ctrl

---
 rtl/bs_host_ctrl_if.sv | 29 ++
 rtl/bs_host_ctrl.sv | 171 +++++++++++++++++
 tb/tb_bs_host_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bs_host_ctrl_if.sv
// rtl/bs_host_ctrl_if.sv - host register bus and processor link bundle for bs_host_ctrl
interface bs_host_ctrl_if;
    logic [3:0]  addr;
    logic        wr_en;
    logic [31:0] wdata;
    logic        rd_en;
    logic [31:0] rdata;
    logic [31:0] constK;
    logic [31:0] const1;
    logic [31:0] const2;
    logic [31:0] const3;
    logic [3:0]  cmd;
    logic [3:0]  status;
    logic [31:0] acc_dout;
    logic [31:0] pow_acc_dout;
    logic        irq;

    // host and processor side: drives the register bus and the processor status/results
    modport master (
        output addr, wr_en, wdata, rd_en, status, acc_dout, pow_acc_dout,
        input  rdata, constK, const1, const2, const3, cmd, irq
    );

    // controller side
    modport slave (
        input  addr, wr_en, wdata, rd_en, status, acc_dout, pow_acc_dout,
        output rdata, constK, const1, const2, const3, cmd, irq
    );
endinterface

// File: rtl/bs_host_ctrl.sv
// rtl/bs_host_ctrl.sv - host register block and run sequencer for the option-pricing processor
module bs_host_ctrl #(
    parameter logic [3:0]  CMD_RUN       = 4'd1,
    parameter logic [3:0]  CMD_ACK       = 4'd2,
    parameter int unsigned START_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          nreset,
    bs_host_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        H_IDLE  = 3'd0,
        H_START = 3'd1,
        H_WAIT  = 3'd2,
        H_CAPT  = 3'd3,
        H_ACK   = 3'd4,
        H_DONE  = 3'd5,
        H_ERR   = 3'd6
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] const_k_q;
    logic [31:0] const1_q;
    logic [31:0] const2_q;
    logic [31:0] const3_q;
    logic [31:0] res_acc_q;
    logic [31:0] res_pow_q;
    logic [31:0] cycles_q;
    logic [31:0] start_cnt_q;
    logic [31:0] rdata_q;
    logic [31:0] rd_mux;
    logic [3:0]  cmd_c;
    logic        done_q;
    logic        err_q;
    logic        irq_q;
    logic        busy;
    logic        wr_ctrl;
    logic        start_ok;
    logic        irq_clr;
    logic        start_expired;

    assign busy          = (state != H_IDLE);
    assign wr_ctrl       = bus.wr_en && (bus.addr == 4'h4);
    assign start_ok      = wr_ctrl && bus.wdata[0] && !busy;
    assign irq_clr       = wr_ctrl && bus.wdata[1];
    // last permitted cycle in H_START is the one where the counter reads START_TIMEOUT-1
    assign start_expired = (start_cnt_q >= START_TIMEOUT - 1);

    // state register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state <= H_IDLE;
        else         state <= state_nxt;
    end

    // next-state logic; status values not expected in a state are simply ignored
    always_comb begin
        state_nxt = state;
        case (state)
            H_IDLE:  if (start_ok) state_nxt = H_START;
            H_START: begin
                if (bus.status == 4'd1)  state_nxt = H_WAIT;
                else if (start_expired)  state_nxt = H_ERR;
            end
            H_WAIT:  if (bus.status == 4'd2) state_nxt = H_CAPT;
            H_CAPT:  state_nxt = H_ACK;
            H_ACK:   if (bus.status == 4'd0) state_nxt = H_DONE;
            H_DONE:  state_nxt = H_IDLE;
            H_ERR:   state_nxt = H_IDLE;
            default: state_nxt = H_IDLE;
        endcase
    end

    // command output decoded from state so reset forces it to zero at once
    always_comb begin
        cmd_c = 4'd0;
        case (state)
            H_START: cmd_c = CMD_RUN;
            H_ACK:   cmd_c = CMD_ACK;
            default: cmd_c = 4'd0;
        endcase
    end

    // cycles spent in H_START, restarted on every entry
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)                start_cnt_q <= 32'd0;
        else if (state != H_START)  start_cnt_q <= 32'd0;
        else                        start_cnt_q <= start_cnt_q + 32'd1;
    end

    // pricing constants, frozen while a run is in flight
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            const_k_q <= 32'd0;
            const1_q  <= 32'd0;
            const2_q  <= 32'd0;
            const3_q  <= 32'd0;
        end else if (bus.wr_en && !busy) begin
            case (bus.addr)
                4'h0:    const_k_q <= bus.wdata;
                4'h1:    const1_q  <= bus.wdata;
                4'h2:    const2_q  <= bus.wdata;
                4'h3:    const3_q  <= bus.wdata;
                default: ;
            endcase
        end
    end

    // run bookkeeping: sticky done/err, saturating wait counter, captured results
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cycles_q  <= 32'd0;
            res_acc_q <= 32'd0;
            res_pow_q <= 32'd0;
        end else begin
            if (start_ok) begin
                done_q   <= 1'b0;
                err_q    <= 1'b0;
                cycles_q <= 32'd0;
            end
            if (state == H_WAIT && cycles_q != 32'hFFFF_FFFF) cycles_q <= cycles_q + 32'd1;
            if (state == H_CAPT) begin
                res_acc_q <= bus.acc_dout;
                res_pow_q <= bus.pow_acc_dout;
            end
            if (state == H_DONE) done_q <= 1'b1;
            if (state == H_ERR)  err_q  <= 1'b1;
        end
    end

    // level interrupt; a set in the same cycle as a clear takes priority
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)                                 irq_q <= 1'b0;
        else if (state == H_DONE || state == H_ERR)  irq_q <= 1'b1;
        else if (irq_clr)                            irq_q <= 1'b0;
    end

    // read mux over current register contents (pre-write on a same-cycle write)
    always_comb begin
        rd_mux = 32'd0;
        case (bus.addr)
            4'h0:    rd_mux = const_k_q;
            4'h1:    rd_mux = const1_q;
            4'h2:    rd_mux = const2_q;
            4'h3:    rd_mux = const3_q;
            4'h5:    rd_mux = {24'd0, err_q, done_q, busy, 2'b00, state};
            4'h6:    rd_mux = res_acc_q;
            4'h7:    rd_mux = res_pow_q;
            4'h8:    rd_mux = cycles_q;
            default: rd_mux = 32'd0;
        endcase
    end

    // registered read data, held between reads
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)        rdata_q <= 32'd0;
        else if (bus.rd_en) rdata_q <= rd_mux;
    end

    assign bus.rdata  = rdata_q;
    assign bus.constK = const_k_q;
    assign bus.const1 = const1_q;
    assign bus.const2 = const2_q;
    assign bus.const3 = const3_q;
    assign bus.cmd    = cmd_c;
    assign bus.irq    = irq_q;

endmodule

// File: tb/tb_bs_host_ctrl.sv
// tb/tb_bs_host_ctrl.sv - randomized scoreboard bench for bs_host_ctrl
module tb_bs_host_ctrl;
    localparam logic [3:0] CMD_RUN       = 4'd1;
    localparam logic [3:0] CMD_ACK       = 4'd2;
    localparam int         START_TIMEOUT = 16;

    logic clk = 1'b0;
    logic nreset;
    bs_host_ctrl_if bus();

    bs_host_ctrl #(
        .CMD_RUN(CMD_RUN),
        .CMD_ACK(CMD_ACK),
        .START_TIMEOUT(START_TIMEOUT)
    ) dut (
        .clk(clk),
        .nreset(nreset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct { logic [3:0] addr; logic [31:0] val; } rd_exp_t;
    rd_exp_t sb[$];

    // reference model of the register file
    logic [31:0] m_const [4];
    logic [31:0] m_acc, m_pow, m_cycles;
    logic        m_done, m_err, m_busy;

    // processor model state
    int          p_ph, p_cnt, p_len;
    bit          p_stuck;
    logic [31:0] p_acc_fin, p_pow_fin;

    // observed command changes and cycles spent issuing RUN
    logic [3:0]  cmd_log[$];
    logic [3:0]  cmd_prev;
    int          run_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_reg(input logic [3:0] a);
        case (a)
            4'h0, 4'h1, 4'h2, 4'h3: return m_const[a[1:0]];
            4'h5: return {24'd0, m_err, m_done, m_busy, 1'b0, (m_busy ? 4'd2 : 4'd0)};
            4'h6: return m_acc;
            4'h7: return m_pow;
            4'h8: return m_cycles;
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_write(input logic [3:0] a, input logic [31:0] d);
        if (a <= 4'h3 && !m_busy) m_const[a[1:0]] = d;
        if (a == 4'h4 && d[0] && !m_busy) begin
            m_busy = 1'b1; m_done = 1'b0; m_err = 1'b0; m_cycles = 32'd0;
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_const[i] = 32'd0;
        m_acc = 32'd0; m_pow = 32'd0; m_cycles = 32'd0;
        m_done = 1'b0; m_err = 1'b0; m_busy = 1'b0;
    endfunction

    function automatic void model_run_done();
        m_busy = 1'b0; m_done = 1'b1; m_cycles = 32'(p_len);
        m_acc = p_acc_fin; m_pow = p_pow_fin;
    endfunction

    function automatic logic [31:0] pack_log();
        logic [31:0] v;
        v = 32'd0;
        foreach (cmd_log[i]) v = {v[27:0], cmd_log[i]};
        v[31:24] = 8'(cmd_log.size());
        return v;
    endfunction

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.addr = a; bus.wdata = d; bus.wr_en = 1'b1;
        model_write(a, d);
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        @(posedge clk); #1;
        bus.addr = a; bus.rd_en = 1'b1;
        sb.push_back('{a, exp_reg(a)});
        @(posedge clk); #1;
        bus.rd_en = 1'b0;
    endtask

    task automatic wr_rd(input logic [3:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.addr = a; bus.wdata = d; bus.wr_en = 1'b1; bus.rd_en = 1'b1;
        sb.push_back('{a, exp_reg(a)});
        model_write(a, d);
        @(posedge clk); #1;
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    endtask

    task automatic check_consts();
        check("constK_out", bus.constK, m_const[0]);
        check("const1_out", bus.const1, m_const[1]);
        check("const2_out", bus.const2, m_const[2]);
        check("const3_out", bus.const3, m_const[3]);
    endtask

    task automatic wait_irq(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.irq) begin ok = 1'b1; break; end
        end
        check("irq_raised", 32'(ok), 32'd1);
    endtask

    task automatic wait_proc(input int n);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < n + 200; i++) begin
            @(negedge clk);
            if (p_ph == 2 && p_cnt >= n) begin ok = 1'b1; break; end
        end
        check("proc_running", 32'(ok), 32'd1);
    endtask

    task automatic wait_ack(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.cmd == CMD_ACK) begin ok = 1'b1; break; end
        end
        check("ack_reached", 32'(ok), 32'd1);
    endtask

    // processor model: RUNNING two cycles after RUN, COMPLETE after p_len running cycles
    initial begin
        int jv;
        bus.status = 4'd0; bus.acc_dout = 32'd0; bus.pow_acc_dout = 32'd0;
        p_ph = 0; p_cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (!nreset) begin
                p_ph = 0; p_cnt = 0; bus.status = 4'd0;
            end else begin
                case (p_ph)
                    0: if (bus.cmd == CMD_RUN && !p_stuck) begin p_ph = 1; p_cnt = 0; end
                    1: begin
                        p_cnt++;
                        if (p_cnt == 2) begin bus.status = 4'd1; p_ph = 2; p_cnt = 0; end
                        else bus.status = 4'd2;
                    end
                    2: begin
                        p_cnt++;
                        bus.acc_dout = $urandom; bus.pow_acc_dout = $urandom;
                        if (p_cnt >= p_len) begin
                            p_acc_fin = $urandom; p_pow_fin = $urandom;
                            bus.acc_dout = p_acc_fin; bus.pow_acc_dout = p_pow_fin;
                            bus.status = 4'd2; p_ph = 3;
                        end else begin
                            jv = int'($urandom_range(0, 15));
                            if (jv == 2) jv = 1;
                            bus.status = 4'(jv);
                        end
                    end
                    default: if (bus.cmd == CMD_ACK) begin
                        bus.status = 4'd0; bus.acc_dout = $urandom; bus.pow_acc_dout = $urandom;
                        p_ph = 0;
                    end
                endcase
            end
        end
    end

    // command recorder
    initial begin
        cmd_prev = 4'd0; run_cyc = 0;
        forever begin
            @(negedge clk);
            if (bus.cmd !== cmd_prev) begin cmd_log.push_back(bus.cmd); cmd_prev = bus.cmd; end
            if (bus.cmd == CMD_RUN) run_cyc++;
        end
    end

    // read-response monitor
    initial begin
        bit seen;
        rd_exp_t e;
        forever begin
            @(posedge clk);
            seen = bus.rd_en && nreset;
            @(negedge clk);
            if (seen) begin
                if (sb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL read_unexpected: rdata 0x%08h with no expected entry", bus.rdata);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("read_addr%0h", e.addr), bus.rdata, e.val);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not reach summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.addr = 4'd0; bus.wdata = 32'd0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        p_stuck = 1'b0; p_len = 1000;
        model_reset();
        nreset = 1'b1;
        #1 nreset = 1'b0;
        #2;
        check("rst_cmd", 32'(bus.cmd), 32'd0);
        check("rst_irq", 32'(bus.irq), 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check_consts();
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        for (int a = 0; a < 9; a++) rd(4'(a));

        wr(4'h0, 32'h42C8_0000);
        for (int a = 1; a < 4; a++) wr(4'(a), $urandom);
        wr_rd(4'h1, 32'h1234_5678);
        rd(4'h1); rd(4'h0);
        check_consts();

        cmd_log.delete(); run_cyc = 0; p_len = 1000;
        wr(4'h4, 32'h1);
        wait_proc(300);
        wr(4'h0, 32'h1);
        rd(4'h0);
        check_consts();
        wr(4'h4, 32'h1);
        rd(4'h5);
        wait_ack(1500);
        wr(4'h4, 32'h2);
        @(negedge clk);
        check("irq_set_wins", 32'(bus.irq), 32'd1);
        model_run_done();
        rd(4'h5); rd(4'h6); rd(4'h7); rd(4'h8);
        check("cmd_seq_run", pack_log(), {8'd4, 24'h001020});
        wr(4'h4, 32'h2);
        @(negedge clk);
        check("irq_cleared", 32'(bus.irq), 32'd0);
        rd(4'h5);

        p_stuck = 1'b1; cmd_log.delete(); run_cyc = 0;
        wr(4'h4, 32'h1);
        wait_irq(60);
        m_busy = 1'b0; m_err = 1'b1;
        check("start_cycles", 32'(run_cyc), 32'(START_TIMEOUT));
        check("cmd_seq_timeout", pack_log(), {8'd2, 24'h000010});
        check("cmd_after_err", 32'(bus.cmd), 32'd0);
        rd(4'h5); rd(4'h6); rd(4'h8);
        wr(4'h4, 32'h2);
        p_stuck = 1'b0;

        for (int it = 0; it < 4; it++) begin
            for (int a = 0; a < 4; a++) wr(4'(a), $urandom);
            p_len = (it == 0) ? 1 : int'($urandom_range(2, 80));
            cmd_log.delete(); run_cyc = 0;
            wr(4'h4, 32'h1);
            wait_irq(p_len + 60);
            model_run_done();
            check("cmd_seq_rand", pack_log(), {8'd4, 24'h001020});
            check_consts();
            for (int a = 0; a < 9; a++) rd(4'(a));
            if (it != 3) begin
                wr(4'h4, 32'h2);
                @(negedge clk);
                check("irq_cleared_rand", 32'(bus.irq), 32'd0);
            end
        end

        p_len = 1000; cmd_log.delete();
        wr(4'h4, 32'h1);
        wait_proc(500);
        nreset = 1'b0;
        #1;
        model_reset();
        check("rst_mid_cmd", 32'(bus.cmd), 32'd0);
        check("rst_mid_irq", 32'(bus.irq), 32'd0);
        check("rst_mid_rdata", bus.rdata, 32'd0);
        check_consts();
        repeat (3) @(posedge clk);
        @(negedge clk);
        nreset = 1'b1;
        repeat (20) @(negedge clk);
        check("cmd_seq_abort", pack_log(), {8'd2, 24'h000010});
        for (int a = 0; a < 9; a++) rd(4'(a));

        p_len = 50; cmd_log.delete();
        wr(4'h4, 32'h1);
        wait_irq(200);
        model_run_done();
        check("cmd_seq_post_rst", pack_log(), {8'd4, 24'h001020});
        rd(4'h5); rd(4'h6); rd(4'h7); rd(4'h8);

        wr(4'h9, 32'hFFFF_FFFF);
        rd(4'h9); rd(4'hF); rd(4'h4);
        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
